// File: rtl/red_sched_pkg.sv
// Shared types for the reduction scheduler: opcode and FSM state enums.
// Latency: n/a (types only). Backpressure: n/a.
package red_sched_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5
  } red_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } red_state_e;

  function automatic logic red_op_legal(input logic [2:0] op);
    return (op <= 3'd5);
  endfunction

endpackage

// File: rtl/red_sched_if.sv
// Request/response bundle between client blocks and the reduction scheduler.
// Latency: n/a (wires only). Backpressure: req_ready per requester, rsp_ready on response.
interface red_sched_if #(
  parameter int NREQ   = 4,
  parameter int DATA_W = 16
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ*3-1:0]      req_op;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [IDW-1:0]         rsp_id;
  logic                   rsp_result;
  logic                   rsp_err;

  modport master (
    output req_valid, req_data, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
  );

  modport slave (
    input  req_valid, req_data, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err
  );

endinterface

// File: rtl/const_reduce.sv
// Purely combinational AND/OR/XOR reduction of one nibble.
// Latency: 0 cycles. Backpressure: none.
module const_reduce #(
  parameter int W = 4
) (
  input  logic [W-1:0] din,
  output logic         red_and,
  output logic         red_or,
  output logic         red_xor
);

  assign red_and = &din;
  assign red_or  = |din;
  assign red_xor = ^din;

endmodule

// File: rtl/red_sched.sv
// Round-robin scheduler sharing one nibble reducer; optional RED_SCHED_EARLY_EXIT_EN ends AND/OR early.
// Latency: legal op DATA_W/4+1 cycles accept-to-response (less with early exit), illegal op 1 cycle.
// Backpressure: response held until rsp_ready; no grant while a transaction is in flight.
module red_sched
  import red_sched_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DATA_W = 16
) (
  input logic        clk,
  input logic        rst_n,
  red_sched_if.slave bus
);

  localparam int IDW  = $clog2(NREQ);
  localparam int NNIB = DATA_W / 4;
  localparam int NBW  = (NNIB > 1) ? $clog2(NNIB) : 1;

  red_state_e        state_q, state_d;
  logic [IDW-1:0]    ptr_q;
  logic [IDW-1:0]    gnt_q;
  logic [DATA_W-1:0] data_q;
  logic [2:0]        op_q;
  logic              err_q;
  logic              and_acc, or_acc, xor_acc;
  logic [NBW-1:0]    nib_q;

  logic              win_vld;
  logic [IDW-1:0]    win_id;
  int                idx;
  logic [DATA_W-1:0] data_sel;
  logic [2:0]        op_sel;
  logic [3:0]        nib_dat;
  logic              red_and, red_or, red_xor;
  logic              last_nib, early_done;
  logic              sel_acc, inv_res;

  // Walk from the highest offset down so the requester closest to ptr wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    idx     = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = (int'(ptr_q) + i) % NREQ;
      if (bus.req_valid[idx]) begin
        win_vld = 1'b1;
        win_id  = idx[IDW-1:0];
      end
    end
  end

  assign data_sel = DATA_W'(bus.req_data >> (DATA_W * int'(win_id)));
  assign op_sel   = 3'(bus.req_op >> (3 * int'(win_id)));

  // Gated by rst_n so nothing looks accepted while reset holds the FSM.
  assign bus.req_ready = (state_q == IDLE && win_vld && rst_n) ? (NREQ'(1) << win_id) : '0;

  assign nib_dat  = 4'(data_q >> {nib_q, 2'b00});
  assign last_nib = (nib_q == NBW'(NNIB - 1));

  const_reduce #(.W(4)) u_reduce (
    .din     (nib_dat),
    .red_and (red_and),
    .red_or  (red_or),
    .red_xor (red_xor)
  );

`ifdef RED_SCHED_EARLY_EXIT_EN
  assign early_done = ((op_q == OP_AND || op_q == OP_NAND) && !red_and) ||
                      ((op_q == OP_OR  || op_q == OP_NOR)  &&  red_or);
`else
  assign early_done = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (win_vld) state_d = red_op_legal(op_sel) ? RUN : RESP;
      RUN:     if (last_nib || early_done) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
      op_q    <= '0;
      err_q   <= 1'b0;
      and_acc <= 1'b1;
      or_acc  <= 1'b0;
      xor_acc <= 1'b0;
      nib_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && win_vld) begin
        data_q  <= data_sel;
        op_q    <= op_sel;
        gnt_q   <= win_id;
        err_q   <= !red_op_legal(op_sel);
        ptr_q   <= (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;
        and_acc <= 1'b1;
        or_acc  <= 1'b0;
        xor_acc <= 1'b0;
        nib_q   <= '0;
      end else if (state_q == RUN) begin
        and_acc <= and_acc & red_and;
        or_acc  <= or_acc | red_or;
        xor_acc <= xor_acc ^ red_xor;
        nib_q   <= nib_q + 1'b1;
      end
    end
  end

  always_comb begin
    sel_acc = 1'b0;
    inv_res = 1'b0;
    case (op_q)
      OP_AND:  sel_acc = and_acc;
      OP_OR:   sel_acc = or_acc;
      OP_XOR:  sel_acc = xor_acc;
      OP_NAND: begin sel_acc = and_acc; inv_res = 1'b1; end
      OP_NOR:  begin sel_acc = or_acc;  inv_res = 1'b1; end
      OP_XNOR: begin sel_acc = xor_acc; inv_res = 1'b1; end
      default: sel_acc = 1'b0;
    endcase
  end

  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_id     = gnt_q;
  assign bus.rsp_err    = (state_q == RESP) && err_q;
  assign bus.rsp_result = (state_q == RESP) && !err_q && (sel_acc ^ inv_res);

endmodule

// File: tb/tb_red_sched.sv
// Self-checking bench for red_sched: directed scenarios plus a randomized run against a transaction model.
module tb_red_sched;
  import red_sched_pkg::*;

  localparam int NREQ   = 4;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;

  red_sched_if #(.NREQ(NREQ), .DATA_W(DATA_W)) bus ();

  red_sched #(.NREQ(NREQ), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic ref_result(input logic [15:0] w, input logic [2:0] op);
    case (op)
      3'd0: return &w;
      3'd1: return |w;
      3'd2: return ^w;
      3'd3: return ~&w;
      3'd4: return ~|w;
      3'd5: return ~^w;
      default: return 1'b0;
    endcase
  endfunction

  // Cycles from the accept cycle to the first cycle with rsp_valid.
  function automatic int ref_lat(input logic [15:0] w, input logic [2:0] op);
    int n;
`ifdef RED_SCHED_EARLY_EXIT_EN
    logic [3:0] nb;
`endif
    if (op > 3'd5) return 1;
    n = 4;
`ifdef RED_SCHED_EARLY_EXIT_EN
    for (int k = 3; k >= 0; k--) begin
      nb = w[4*k +: 4];
      if ((op == 3'd0 || op == 3'd3) && nb != 4'hF) n = k + 1;
      if ((op == 3'd1 || op == 3'd4) && nb != 4'h0) n = k + 1;
    end
`endif
    return n + 1;
  endfunction

  task automatic do_reset();
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Drives one request and captures the response; expects to start just after a rising edge.
  task automatic issue(input int id, input logic [15:0] d, input logic [2:0] op,
                       output int t_acc, output int t_rsp,
                       output logic [1:0] rid, output logic res, output logic err);
    t_acc = -1; t_rsp = -1; rid = '0; res = 1'b0; err = 1'b0;
    bus.req_valid[id] = 1'b1;
    bus.req_data[id*DATA_W +: DATA_W] = d;
    bus.req_op[id*3 +: 3] = op;
    for (int i = 0; i < 60 && t_acc < 0; i++) begin
      @(negedge clk);
      if (bus.req_ready[id]) t_acc = cyc;
      @(posedge clk);
      #1;
    end
    bus.req_valid[id] = 1'b0;
    for (int i = 0; i < 60 && t_acc >= 0 && t_rsp < 0; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        t_rsp = cyc; rid = bus.rsp_id; res = bus.rsp_result; err = bus.rsp_err;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 4'hF;
    #1;
    n_vec++; if (bus.req_ready !== 4'h0) begin n_err++; $display("FAIL reset_req_ready got=%h exp=0", bus.req_ready); end
    n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
    n_vec++; if (bus.rsp_result !== 1'b0) begin n_err++; $display("FAIL reset_rsp_result got=%b exp=0", bus.rsp_result); end
    n_vec++; if (bus.rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp_err got=%b exp=0", bus.rsp_err); end
    n_vec++; if (bus.rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id got=%0d exp=0", bus.rsp_id); end
    bus.req_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_xor();
    int ta, tr, id; logic [1:0] rid; logic res, err; logic [15:0] d; logic [2:0] op;
    bus.rsp_ready = 1'b1;
    issue(2, 16'h8001, 3'd2, ta, tr, rid, res, err);
    n_vec++; if (tr - ta !== 5 || ta < 0) begin n_err++; $display("FAIL xor_latency got=%0d exp=5", tr - ta); end
    n_vec++; if (rid !== 2'd2) begin n_err++; $display("FAIL xor_id got=%0d exp=2", rid); end
    n_vec++; if (res !== 1'b0) begin n_err++; $display("FAIL xor_result got=%b exp=0", res); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL xor_err got=%b exp=0", err); end
    for (int n = 0; n < 6; n++) begin
      id = $urandom_range(0, 3); d = 16'($urandom); op = 3'($urandom_range(0, 5));
      issue(id, d, op, ta, tr, rid, res, err);
      n_vec++; if (tr - ta !== ref_lat(d, op) || ta < 0) begin n_err++; $display("FAIL rand_latency op=%0d d=%h got=%0d exp=%0d", op, d, tr - ta, ref_lat(d, op)); end
      n_vec++; if (rid !== 2'(id)) begin n_err++; $display("FAIL rand_id got=%0d exp=%0d", rid, id); end
      n_vec++; if (res !== ref_result(d, op)) begin n_err++; $display("FAIL rand_result op=%0d d=%h got=%b exp=%b", op, d, res, ref_result(d, op)); end
    end
  endtask

  task automatic test_nor_zero();
    int ta, tr; logic [1:0] rid; logic res, err;
    bus.rsp_ready = 1'b1;
    issue(1, 16'h0000, 3'd4, ta, tr, rid, res, err);
    n_vec++; if (res !== 1'b1) begin n_err++; $display("FAIL nor_zero got=%b exp=1", res); end
    issue(3, 16'h0000, 3'd1, ta, tr, rid, res, err);
    n_vec++; if (res !== 1'b0) begin n_err++; $display("FAIL or_zero got=%b exp=0", res); end
    n_vec++; if (tr - ta !== 5 || ta < 0) begin n_err++; $display("FAIL or_zero_latency got=%0d exp=5", tr - ta); end
    issue(0, 16'hFFFF, 3'd3, ta, tr, rid, res, err);
    n_vec++; if (res !== 1'b0) begin n_err++; $display("FAIL nand_ones got=%b exp=0", res); end
    issue(2, 16'hFFFF, 3'd5, ta, tr, rid, res, err);
    n_vec++; if (res !== 1'b1) begin n_err++; $display("FAIL xnor_ones got=%b exp=1", res); end
  endtask

  task automatic test_round_robin();
    logic [15:0] d[4]; logic [2:0] o[4];
    int n_gnt, mptr, w, cur; bit pend; logic cres;
    do_reset();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d[i] = 16'($urandom); o[i] = 3'($urandom_range(0, 5));
      bus.req_data[i*16 +: 16] = d[i]; bus.req_op[i*3 +: 3] = o[i];
    end
    bus.req_valid = 4'hF;
    n_gnt = 0; mptr = 0; pend = 1'b0; cur = 0; cres = 1'b0;
    for (int c = 0; c < 200 && n_gnt < 5; c++) begin
      w = -1;
      @(negedge clk);
      if (bus.rsp_valid && pend) begin
        n_vec++; if (bus.rsp_id !== 2'(cur)) begin n_err++; $display("FAIL rr_rsp_id got=%0d exp=%0d", bus.rsp_id, cur); end
        n_vec++; if (bus.rsp_result !== cres) begin n_err++; $display("FAIL rr_result got=%b exp=%b", bus.rsp_result, cres); end
        pend = 1'b0;
      end
      if (bus.req_ready != 4'h0) begin
        for (int k = 0; k < 4; k++) if (bus.req_ready[k]) w = k;
        n_vec++; if (!$onehot(bus.req_ready)) begin n_err++; $display("FAIL rr_onehot got=%b exp=onehot", bus.req_ready); end
        n_vec++; if (w !== mptr) begin n_err++; $display("FAIL rr_order grant#%0d got=%0d exp=%0d", n_gnt, w, mptr); end
        n_vec++; if (pend) begin n_err++; $display("FAIL rr_overlap got=grant_before_rsp exp=rsp_first"); end
        cur = w; cres = ref_result(d[w], o[w]); pend = 1'b1;
        mptr = (mptr + 1) % 4;
        n_gnt++;
      end
      @(posedge clk);
      #1;
      if (w >= 0) begin
        d[w] = 16'($urandom); o[w] = 3'($urandom_range(0, 5));
        bus.req_data[w*16 +: 16] = d[w]; bus.req_op[w*3 +: 3] = o[w];
      end
    end
    n_vec++; if (n_gnt !== 5) begin n_err++; $display("FAIL rr_grant_count got=%0d exp=5", n_gnt); end
    bus.req_valid = '0;
  endtask

  task automatic test_illegal_backpressure();
    int ta, tr; logic [1:0] rid; logic res, err; logic [2:0] op;
    do_reset();
    bus.rsp_ready = 1'b0;
    op = 3'(6 + $urandom_range(0, 1));
    issue(1, 16'($urandom), op, ta, tr, rid, res, err);
    n_vec++; if (tr - ta !== 1 || ta < 0) begin n_err++; $display("FAIL illegal_latency got=%0d exp=1", tr - ta); end
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL illegal_err got=%b exp=1", err); end
    n_vec++; if (res !== 1'b0) begin n_err++; $display("FAIL illegal_result got=%b exp=0", res); end
    n_vec++; if (rid !== 2'd1) begin n_err++; $display("FAIL illegal_id got=%0d exp=1", rid); end
    bus.req_valid[0] = 1'b1;
    bus.req_data[15:0] = 16'($urandom);
    bus.req_op[2:0] = 3'd2;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_vec++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL hold_valid c=%0d got=%b exp=1", c, bus.rsp_valid); end
      n_vec++; if (bus.rsp_err !== 1'b1) begin n_err++; $display("FAIL hold_err c=%0d got=%b exp=1", c, bus.rsp_err); end
      n_vec++; if (bus.rsp_result !== 1'b0) begin n_err++; $display("FAIL hold_result c=%0d got=%b exp=0", c, bus.rsp_result); end
      n_vec++; if (bus.rsp_id !== 2'd1) begin n_err++; $display("FAIL hold_id c=%0d got=%0d exp=1", c, bus.rsp_id); end
      n_vec++; if (bus.req_ready !== 4'h0) begin n_err++; $display("FAIL hold_no_grant c=%0d got=%b exp=0", c, bus.req_ready); end
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1 bus.rsp_ready = 1'b0;
    @(negedge clk);
    n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL after_rsp_valid got=%b exp=0", bus.rsp_valid); end
    n_vec++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL next_grant got=%b exp=0001", bus.req_ready); end
    bus.req_valid = '0;
  endtask

  task automatic test_early_exit();
    int ta, tr; logic [1:0] rid; logic res, err; int exp_lat;
`ifdef RED_SCHED_EARLY_EXIT_EN
    exp_lat = 2;
`else
    exp_lat = 5;
`endif
    do_reset();
    bus.rsp_ready = 1'b1;
    issue(0, 16'hFFF0, 3'd0, ta, tr, rid, res, err);
    n_vec++; if (tr - ta !== exp_lat || ta < 0) begin n_err++; $display("FAIL early_and_latency got=%0d exp=%0d", tr - ta, exp_lat); end
    n_vec++; if (res !== 1'b0) begin n_err++; $display("FAIL early_and_result got=%b exp=0", res); end
    issue(3, 16'h0010, 3'd4, ta, tr, rid, res, err);
    n_vec++; if (tr - ta !== ref_lat(16'h0010, 3'd4) || ta < 0) begin n_err++; $display("FAIL early_nor_latency got=%0d exp=%0d", tr - ta, ref_lat(16'h0010, 3'd4)); end
    n_vec++; if (res !== 1'b0) begin n_err++; $display("FAIL early_nor_result got=%b exp=0", res); end
  endtask

  task automatic test_reset_mid_run();
    int ta, tr, t0; logic [1:0] rid; logic res, err;
    do_reset();
    bus.rsp_ready = 1'b1;
    bus.req_valid[2] = 1'b1;
    bus.req_data[47:32] = 16'($urandom);
    bus.req_op[8:6] = 3'd2;
    t0 = -1;
    for (int i = 0; i < 20 && t0 < 0; i++) begin
      @(negedge clk);
      if (bus.req_ready[2]) t0 = cyc;
      @(posedge clk);
      #1;
    end
    n_vec++; if (t0 < 0) begin n_err++; $display("FAIL midrun_accept got=timeout exp=grant"); end
    bus.req_valid = 4'b1011;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL midrun_rsp_valid got=%b exp=0", bus.rsp_valid); end
    n_vec++; if (bus.req_ready !== 4'h0) begin n_err++; $display("FAIL midrun_req_ready got=%b exp=0", bus.req_ready); end
    n_vec++; if (bus.rsp_id !== 2'd0) begin n_err++; $display("FAIL midrun_rsp_id got=%0d exp=0", bus.rsp_id); end
    bus.req_valid = 4'b1010;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL ptr_reset_grant got=%b exp=0010", bus.req_ready); end
    n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL discarded_rsp got=%b exp=0", bus.rsp_valid); end
    bus.req_valid = '0;
    @(posedge clk);
    #1;
    issue(3, 16'($urandom), 3'd1, ta, tr, rid, res, err);
    n_vec++; if (ta < 0 || rid !== 2'd3) begin n_err++; $display("FAIL req3_after_reset got=%0d exp=3", rid); end
  endtask

  task automatic test_random();
    logic [15:0] d[4]; logic [2:0] o[4]; bit pend[4];
    int mptr, rsp_at, cur, w; bit busy; logic eres, eerr; logic [3:0] exp_rdy;
    do_reset();
    mptr = 0; busy = 1'b0; rsp_at = 0; cur = 0; eres = 1'b0; eerr = 1'b0;
    for (int i = 0; i < 4; i++) begin d[i] = '0; o[i] = '0; pend[i] = 1'b0; end
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          d[i] = 16'($urandom);
          if ($urandom_range(0, 3) == 0) d[i] = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'h0000;
          o[i] = ($urandom_range(0, 7) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
        end
        bus.req_valid[i] = pend[i];
        bus.req_data[i*16 +: 16] = d[i];
        bus.req_op[i*3 +: 3] = o[i];
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (!busy) begin
        w = -1;
        for (int k = 3; k >= 0; k--) if (pend[(mptr + k) % 4]) w = (mptr + k) % 4;
        exp_rdy = (w >= 0) ? 4'(1 << w) : 4'h0;
        n_vec++; if (bus.req_ready !== exp_rdy) begin n_err++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", cyc, bus.req_ready, exp_rdy); end
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rnd_idle_valid cyc=%0d got=%b exp=0", cyc, bus.rsp_valid); end
        if (w >= 0) begin
          busy = 1'b1; cur = w;
          rsp_at = cyc + ref_lat(d[w], o[w]);
          eres = ref_result(d[w], o[w]);
          eerr = (o[w] > 3'd5);
          mptr = (w + 1) % 4;
          pend[w] = 1'b0;
        end
      end else begin
        n_vec++; if (bus.req_ready !== 4'h0) begin n_err++; $display("FAIL rnd_busy_grant cyc=%0d got=%b exp=0", cyc, bus.req_ready); end
        if (cyc < rsp_at) begin
          n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL rnd_early_rsp cyc=%0d got=%b exp=0", cyc, bus.rsp_valid); end
        end else begin
          n_vec++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=1", cyc, bus.rsp_valid); end
          n_vec++; if (bus.rsp_id !== 2'(cur)) begin n_err++; $display("FAIL rnd_rsp_id cyc=%0d got=%0d exp=%0d", cyc, bus.rsp_id, cur); end
          n_vec++; if (bus.rsp_result !== eres) begin n_err++; $display("FAIL rnd_result cyc=%0d got=%b exp=%b", cyc, bus.rsp_result, eres); end
          n_vec++; if (bus.rsp_err !== eerr) begin n_err++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, bus.rsp_err, eerr); end
          if (bus.rsp_ready) busy = 1'b0;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_op    = '0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    test_reset();
    test_single_xor();
    test_nor_zero();
    test_round_robin();
    test_illegal_backpressure();
    test_early_exit();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/red_sched.md
# red_sched

Shared-resource scheduler for the 4-bit reduction unit. Up to NREQ requesters each submit a DATA_W-bit word and a reduction opcode. The block grants one requester at a time in round-robin order and streams the word through a single `const_reduce` instance one nibble per cycle, folding the partial results. It returns the 1-bit result with the requester ID over a valid/ready response channel. It sits between the client blocks and the reduction datapath, so that only one reduction unit is needed in the design.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..16)
- DATA_W, 16, request word width; a multiple of 4, at least 4

Ports:
- clk  input  1  clock; all logic is rising-edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept; at most one bit high
- req_data  input  NREQ*DATA_W  request words; requester i occupies [i*DATA_W +: DATA_W]
- req_op  input  NREQ*3  opcodes; requester i occupies [i*3 +: 3]
- rsp_valid  output  1  response valid
- rsp_ready  input  1  response accept
- rsp_id  output  $clog2(NREQ)  index of the requester being answered
- rsp_result  output  1  reduction result
- rsp_err  output  1  illegal opcode was received

## Operation
- Opcodes: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR. Codes 6 and 7 are illegal.
- FSM states are IDLE, RUN and RESP.
- **IDLE:**
  - Arbitrate round-robin over req_valid, searching from ptr upward and wrapping.
  - req_ready[g] is combinational: it is high only for the winner g, and only while in IDLE.
  - On the handshake (req_valid[g] & req_ready[g]):
    - Latch data, op and g.
    - Set ptr to (g+1) mod NREQ.
    - Initialise the accumulators: and_acc=1, or_acc=0, xor_acc=0, nib=0.
  - A legal op goes to RUN. An illegal op goes to RESP with err=1.
- **RUN:**
  - Each cycle, nibble nib (bits [4*nib+3:4*nib], starting from the LSB) drives the reduction unit.
  - Fold: and_acc&=red_and, or_acc|=red_or, xor_acc^=red_xor. Then increment nib.
  - After nibble DATA_W/4-1, go to RESP.
- **RESP:**
  - rsp_valid=1 and rsp_id=g.
  - rsp_result is the selected accumulator; inverted for NAND, NOR and XNOR; forced to 0 when err=1.
  - Outputs are held stable until rsp_ready. On rsp_valid & rsp_ready, go to IDLE.
- Requesters hold req_valid, req_data and req_op stable until accepted. Non-granted requesters wait; no request is ever dropped.
- Only one transaction is in flight at a time. No new grant is made while in RUN or RESP.
- rsp_ready being high outside RESP has no effect.
- **Reset (asynchronous, any state):**
  - State returns to IDLE, ptr=0.
  - rsp_valid, rsp_result, rsp_err and rsp_id go to 0.
  - Any in-flight transaction is discarded.

## Timing
- Legal op accepted at edge T:
  - RUN occupies cycles T+1 .. T+DATA_W/4.
  - rsp_valid is high from cycle T+DATA_W/4+1. With DATA_W=16 that is T+5.
- Illegal op accepted at edge T: rsp_valid at T+1.
- The earliest next grant is the cycle after the response handshake.
- The peak rate is one request per DATA_W/4+2 cycles.
- req_ready depends combinationally on req_valid and state, so there is a path from req_valid to req_ready. There is no combinational path from rsp_ready to any output.

## Configuration
- Macro: RED_SCHED_EARLY_EXIT_EN.
- When defined, RUN leaves early as soon as the result is determined:
  - AND/NAND: the RUN cycle where red_and=0 is the last one.
  - OR/NOR: the RUN cycle where red_or=1 is the last one.
  - RESP follows on the next cycle.
  - XOR/XNOR always run the full length.
- When undefined, every legal op runs exactly DATA_W/4 cycles.
- Results are identical in both builds; only latency differs.

## Structure
- Package red_sched_pkg holds:
  - red_op_e, the 3-bit opcode enum, and the function red_op_legal().
  - red_state_e, the state enum (IDLE, RUN, RESP).
- Sub-module: one `const_reduce` instance, fed by the nibble mux.
- The round-robin arbiter stays inline. It is small enough that no separate module is needed.

## Test plan
All cases use NREQ=4 and DATA_W=16.
- **Single XOR:** requester 2, data 0x8001, op XOR, rsp_ready=1 → rsp_valid at T+5, rsp_id=2, rsp_result=0, rsp_err=0.
- **NOR on zero:** data 0x0000, op NOR → rsp_result=1. With the same data, op OR → rsp_result=0.
- **Round-robin:**
  - Setup: all four requesters valid continuously, ptr=0.
  - Required grant order: 0,1,2,3,0.
  - Required: each response arrives before the next req_ready; no requester is starved.
- **Illegal op and backpressure:**
  - Op 6 → rsp_valid at T+1, rsp_err=1, rsp_result=0.
  - Hold rsp_ready=0 for 10 cycles → outputs stable, no new req_ready.
- **Early exit:** op AND, data 0xFFF0.
  - With RED_SCHED_EARLY_EXIT_EN: rsp at T+2, result 0.
  - Without the macro: rsp at T+5, result 0.
- **Reset mid-RUN:**
  - Assert rst_n=0 asynchronously at T+2 of a transaction.
  - Required immediately: rsp_valid=0, req_ready=0.
  - After release, requester 3 is granted first from ptr=0 only when requesters 0–2 are idle.
